// File: rtl/alu_mem_seq.sv
// alu_mem_seq: command-sequenced Hack ALU over a small internal register memory.
// Optional macro FWD_EN: accept the next command during write-back (write-first read path).
module alu_mem_seq #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_ctrl,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic              cmd_wb,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic [WIDTH-1:0]  host_rdata,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_zr,
  output logic              res_ng,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  state_t            state;
  logic [5:0]        ctrl_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic              wb_q;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_en;
  logic              accept;
  logic [WIDTH-1:0]  alu_x;
  logic [WIDTH-1:0]  alu_y;
  logic [WIDTH-1:0]  alu_o;

`ifdef FWD_EN
  assign cmd_ready = rst_n && !host_we && (state == IDLE || state == WB);
`else
  assign cmd_ready = rst_n && !host_we && (state == IDLE);
`endif
  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);

  // Single write port shared by host (IDLE only) and result write-back (WB only).
  always_comb begin
    rd_addr = (state == RD_B) ? src_b_q : src_a_q;
    wr_en   = 1'b0;
    wr_addr = host_addr;
    wr_data = host_wdata;
    if (rst_n && state == IDLE && host_we) begin
      wr_en = 1'b1;
    end else if (rst_n && state == WB && wb_q) begin
      wr_en   = 1'b1;
      wr_addr = dst_q;
      wr_data = res_data;
    end
  end

  always_comb begin
    alu_x = ctrl_q[5] ? '0 : op_a;
    if (ctrl_q[4]) alu_x = ~alu_x;
    alu_y = ctrl_q[3] ? '0 : rd_data;
    if (ctrl_q[2]) alu_y = ~alu_y;
    alu_o = ctrl_q[1] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ctrl_q[0]) alu_o = ~alu_o;
  end

  // Memory array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
`ifdef FWD_EN
    rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
`else
    rd_data <= mem[rd_addr];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctrl_q     <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      wb_q       <= 1'b0;
      op_a       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_zr     <= 1'b0;
      res_ng     <= 1'b0;
      host_rdata <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          host_rdata <= mem[host_addr];
          if (accept) state <= RD_A;
        end
        RD_A: state <= RD_B;
        RD_B: begin
          op_a  <= rd_data;
          state <= EXEC;
        end
        EXEC: begin
          res_data  <= alu_o;
          res_zr    <= (alu_o == '0);
          res_ng    <= alu_o[WIDTH-1];
          res_valid <= 1'b1;
          state     <= WB;
        end
        WB:      state <= accept ? RD_A : IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        ctrl_q  <= cmd_ctrl;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
        wb_q    <= cmd_wb;
      end
    end
  end

endmodule

// File: tb/tb_alu_mem_seq.sv
// tb_alu_mem_seq: directed + randomized bench for alu_mem_seq with a queue-based timing model.
module tb_alu_mem_seq;
  localparam int WIDTH = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH = 8;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [5:0]        cmd_ctrl = '0;
  logic [ADDR_W-1:0] cmd_src_a = '0;
  logic [ADDR_W-1:0] cmd_src_b = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic              cmd_wb = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [WIDTH-1:0]  host_wdata = '0;
  logic [WIDTH-1:0]  host_rdata;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic              res_zr;
  logic              res_ng;
  logic              busy;

  always #5 clk = ~clk;

  alu_mem_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_wb(cmd_wb),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .res_valid(res_valid), .res_data(res_data), .res_zr(res_zr), .res_ng(res_ng), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int edges = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic [5:0] c);
    logic [WIDTH-1:0] xx, yy, o;
    xx = c[5] ? '0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? '0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? WIDTH'(xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  // Reference model: each accepted command is occupied for edges acc..acc+3, result visible
  // after edge acc+3, write-back lands at edge acc+4.
  typedef struct {
    int                acc;
    logic [5:0]        ctrl;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] d;
    logic              wb;
  } cmd_t;

  cmd_t             q[$];
  logic [WIDTH-1:0] mm [DEPTH];
  logic [DEPTH-1:0] known = '0;
  logic [WIDTH-1:0] front_res = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_zr = 1'b0;
  logic             exp_ng = 1'b0;
  logic [WIDTH-1:0] exp_hr = '0;
  logic             hr_known = 1'b1;

  always @(negedge clk) begin
    logic idle, exp_v, exp_rdy;
    while (q.size() > 0 && q[0].acc + 4 <= edges) begin
      if (q[0].wb) begin
        mm[q[0].d] = front_res;
        known[q[0].d] = 1'b1;
      end
      void'(q.pop_front());
    end
    if (!rst_n) begin
      q.delete();
      exp_data = '0; exp_zr = 1'b0; exp_ng = 1'b0;
      exp_hr = '0; hr_known = 1'b1;
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_res_data", {16'b0, res_data}, {16'b0, exp_data});
      chk("rst_host_rdata", {16'b0, host_rdata}, {16'b0, exp_hr});
    end else begin
      idle  = !(q.size() > 0 && q[0].acc <= edges);
      exp_v = q.size() > 0 && q[0].acc + 3 == edges;
      if (exp_v) begin
        front_res = alu(mm[q[0].a], mm[q[0].b], q[0].ctrl);
        exp_data  = front_res;
        exp_zr    = (front_res == '0);
        exp_ng    = front_res[WIDTH-1];
      end
      exp_rdy = !host_we && (idle || (FWD && exp_v));
      chk("res_valid", {31'b0, res_valid}, {31'b0, exp_v});
      chk("busy", {31'b0, busy}, {31'b0, !idle});
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_rdy});
      chk("res_data", {16'b0, res_data}, {16'b0, exp_data});
      chk("res_zr", {31'b0, res_zr}, {31'b0, exp_zr});
      chk("res_ng", {31'b0, res_ng}, {31'b0, exp_ng});
      if (hr_known) chk("host_rdata", {16'b0, host_rdata}, {16'b0, exp_hr});
      if (idle) begin
        exp_hr   = mm[host_addr];
        hr_known = known[host_addr];
        if (host_we) begin
          mm[host_addr]    = host_wdata;
          known[host_addr] = 1'b1;
        end
      end
      if (cmd_valid && exp_rdy)
        q.push_back('{edges + 1, cmd_ctrl, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wait_idle();
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] v);
    wait_idle();
    host_addr = a;
    tick();
    v = host_rdata;
  endtask

  task automatic issue(input logic [5:0] c, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] d, input logic w);
    int n = 0;
    cmd_ctrl = c; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_wb = w;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("accept_timeout", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
  endtask

  initial begin
    int n, p1, p2;
    logic [WIDTH-1:0] v, m3, m4;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    host_write(3'd0, 16'h9599);
    host_write(3'd1, 16'h8BFD);
    for (int i = 2; i < DEPTH; i++) host_write(ADDR_W'(i), WIDTH'($urandom));
    host_read(3'd3, m3);
    host_read(3'd4, m4);

    // Add with write-back
    issue(6'b000010, 3'd0, 3'd1, 3'd2, 1'b1);
    wait_res(n);
    chk("t1_latency", n, 32'd3);
    chk("t1_data", {16'b0, res_data}, 32'h2196);
    chk("t1_zr", {31'b0, res_zr}, 32'd0);
    chk("t1_ng", {31'b0, res_ng}, 32'd0);
    host_read(3'd2, v);
    chk("t1_mem2", {16'b0, v}, 32'h2196);

    // Constant zero
    issue(6'b101010, 3'd0, 3'd1, 3'd5, 1'b0);
    wait_res(n);
    chk("t2_data", {16'b0, res_data}, 32'h0);
    chk("t2_zr", {31'b0, res_zr}, 32'd1);
    chk("t2_ng", {31'b0, res_ng}, 32'd0);

    // AND without write-back
    issue(6'b000000, 3'd0, 3'd1, 3'd3, 1'b0);
    wait_res(n);
    chk("t3_data", {16'b0, res_data}, 32'h8199);
    chk("t3_ng", {31'b0, res_ng}, 32'd1);
    host_read(3'd3, v);
    chk("t3_mem3", {16'b0, v}, {16'b0, m3});

    // Host write beats command in the same cycle
    wait_idle();
    host_we = 1'b1; host_addr = 3'd6; host_wdata = 16'h1234;
    cmd_ctrl = 6'b000010; cmd_src_a = 3'd6; cmd_src_b = 3'd6; cmd_dst = 3'd7; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("t4_ready_blocked", {31'b0, cmd_ready}, 32'd0);
    tick();
    host_we = 1'b0;
    #1;
    chk("t4_ready_next", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    wait_res(n);
    chk("t4_data", {16'b0, res_data}, 32'h2468);

    // Reset during EXEC
    issue(6'b000010, 3'd0, 3'd1, 3'd4, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_res_valid", {31'b0, res_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_pulse", {31'b0, res_valid}, 32'd0);
    end
    host_read(3'd4, v);
    chk("t5_mem_dst", {16'b0, v}, {16'b0, m4});
    host_read(3'd0, v);
    chk("t5_mem0", {16'b0, v}, 32'h9599);

    // Command offered during write-back
    issue(6'b000010, 3'd0, 3'd1, 3'd2, 1'b1);
    wait_res(n);
    p1 = edges;
    cmd_ctrl = 6'b000010; cmd_src_a = 3'd2; cmd_src_b = 3'd0; cmd_dst = 3'd4; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("t6_ready_in_wb", {31'b0, cmd_ready}, {31'b0, FWD});
    issue(6'b000010, 3'd2, 3'd0, 3'd4, 1'b1);
    wait_res(n);
    p2 = edges;
    chk("t6_data", {16'b0, res_data}, 32'hB72F);
    chk("t6_spacing", p2 - p1, FWD ? 32'd4 : 32'd5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = ($urandom % 3) != 0;
      cmd_ctrl   = 6'($urandom);
      cmd_src_a  = ADDR_W'($urandom);
      cmd_src_b  = ADDR_W'($urandom);
      cmd_dst    = ADDR_W'($urandom);
      cmd_wb     = 1'($urandom);
      host_we    = ($urandom % 8) == 0;
      host_addr  = ADDR_W'($urandom);
      host_wdata = WIDTH'($urandom);
      rst_n      = ($urandom % 300) != 0;
      tick();
    end
    cmd_valid = 1'b0;
    host_we = 1'b0;
    rst_n = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
